// File: rtl/mod_bus_rx_pkg.sv
// Shared payload type for the dual-rail bus link.
package mod_bus_rx_pkg;

  localparam int unsigned BUS_W = 12;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] data;
  } bus_t;

endpackage

// File: rtl/mod_bus_rx_if.sv
// Handshake/bus bundle for mod_bus_rx; o_err_cnt exists only with BUS_RX_ERR_CNT_EN.
interface mod_bus_rx_if #(
  parameter int unsigned DEPTH = 4
);
  import mod_bus_rx_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  bus_t          i_Q;
  bus_t          i_nQ;
  logic          i_ready;
  logic          i_clr;
  logic          o_valid;
  bus_t          o_data;
  logic [CW-1:0] o_count;
  logic          o_ovf;
  logic          o_err;
  logic          o_fault;
`ifdef BUS_RX_ERR_CNT_EN
  logic [7:0]    o_err_cnt;

  modport slave (
    input  i_Q, i_nQ, i_ready, i_clr,
    output o_valid, o_data, o_count, o_ovf, o_err, o_fault, o_err_cnt
  );

  modport master (
    output i_Q, i_nQ, i_ready, i_clr,
    input  o_valid, o_data, o_count, o_ovf, o_err, o_fault, o_err_cnt
  );
`else
  modport slave (
    input  i_Q, i_nQ, i_ready, i_clr,
    output o_valid, o_data, o_count, o_ovf, o_err, o_fault
  );

  modport master (
    output i_Q, i_nQ, i_ready, i_clr,
    input  o_valid, o_data, o_count, o_ovf, o_err, o_fault
  );
`endif

endinterface

// File: rtl/mod_bus_rx.sv
// Dual-rail bus receiver: rail integrity check, idle discard, FIFO with valid/ready, fault FSM.
// Optional saturating mismatch counter on o_err_cnt when BUS_RX_ERR_CNT_EN is defined.
module mod_bus_rx #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FAULT_LIM = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mod_bus_rx_if.slave  bus
);
  import mod_bus_rx_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              valid_q, valid_d;
  bus_t              data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  bus_t              mem [DEPTH];

  logic [BUS_W-1:0]  q_raw;
  logic [BUS_W-1:0]  nq_raw;
  bus_t              word;
  logic              mismatch;
  logic              good;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  // Input classification: rails must be exact complements; tag 0 marks idle.
  assign word     = bus.i_Q;
  assign q_raw    = bus.i_Q;
  assign nq_raw   = bus.i_nQ;
  assign mismatch = (nq_raw != ~q_raw);
  assign good     = !mismatch && (word.tag != 4'h0);
  assign full     = (count_q == CW'(DEPTH));

  // Next-state: FSM, run counter, FIFO pointers, registered head and sticky flags.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q & ~bus.i_clr;
    err_d   = err_q & ~bus.i_clr;
    push    = 1'b0;
    drop    = 1'b0;
    pop     = valid_q & bus.i_ready;

    case (state_q)
      ST_RUN: begin
        if (bus.i_clr) begin
          run_d = 4'd0;
        end else if (mismatch) begin
          run_d = run_q + 4'd1;
          if (({1'b0, run_q} + 5'd1) >= 5'(FAULT_LIM)) begin
            state_d = ST_FAULT;
          end
        end else begin
          run_d = 4'd0;
        end
        if (good) begin
          if (!full || pop) begin
            push = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (bus.i_clr) begin
          state_d = ST_RUN;
          run_d   = 4'd0;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (mismatch) begin
      err_d = 1'b1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end

    rptr_d  = rptr_q + AW'(pop);
    wptr_d  = wptr_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    valid_d = (count_d != '0);

    // Head moves on a pop, or when the first word lands in an empty FIFO.
    if ((pop || (push && count_q == '0)) && count_d != '0) begin
      data_d = (push && wptr_q == rptr_d) ? word : mem[rptr_d];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      run_q   <= 4'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Storage array carries no reset; pointers and count define what is live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wptr_q] <= word;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_count = count_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_err   = err_q;
  assign bus.o_fault = (state_q == ST_FAULT);

`ifdef BUS_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (mismatch && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mod_bus_rx.sv
// Directed self-checking bench for mod_bus_rx (DEPTH=4, FAULT_LIM=4).
module tb_mod_bus_rx;
  import mod_bus_rx_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_bus_rx_if #(.DEPTH(4)) bus ();

  mod_bus_rx #(.DEPTH(4), .FAULT_LIM(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // Apply one cycle of inputs; returns on the following falling edge.
  task automatic drive(input logic [11:0] q, input logic [11:0] nq,
                       input logic rdy, input logic clr);
    bus.i_Q     = q;
    bus.i_nQ    = nq;
    bus.i_ready = rdy;
    bus.i_clr   = clr;
    @(negedge clk);
  endtask

  task automatic good(input logic [11:0] q, input logic rdy, input logic clr);
    drive(q, ~q, rdy, clr);
  endtask

  task automatic idle(input logic rdy, input logic clr);
    drive(12'h000, 12'hFFF, rdy, clr);
  endtask

  task automatic test_reset;
    logic [18:0] obs;
    rst_n = 1'b0;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1'b0, 1'b0);
      obs = {bus.o_valid, bus.o_data, bus.o_count, bus.o_ovf, bus.o_err, bus.o_fault};
      checks++;
      if (obs !== 19'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got %h want 0", i, obs);
      end
    end
`ifdef BUS_RX_ERR_CNT_EN
    checks++;
    if (bus.o_err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_err_cnt got %0d want 0", bus.o_err_cnt);
    end
`endif
  endtask

  task automatic test_latency;
    drive(12'h3A5, 12'hC5A, 1'b0, 1'b0);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 12'h3A5 || bus.o_count !== 3'd1) begin
      errors++;
      $display("FAIL latency got v=%b d=%h c=%0d want v=1 d=3a5 c=1",
               bus.o_valid, bus.o_data, bus.o_count);
    end
    idle(1'b1, 1'b0);
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0) begin
      errors++;
      $display("FAIL latency_pop got v=%b c=%0d want v=0 c=0", bus.o_valid, bus.o_count);
    end
  endtask

  task automatic test_overflow;
    logic [11:0] exp;
    for (int i = 1; i <= 5; i++) good(12'h100 + 12'(i), 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd4 || bus.o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow got c=%0d ovf=%b want c=4 ovf=1", bus.o_count, bus.o_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      exp = 12'h101 + 12'(i);
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp) begin
        errors++;
        $display("FAIL overflow_pop %0d got v=%b d=%h want v=1 d=%h", i, bus.o_valid, bus.o_data, exp);
      end
      idle(1'b1, 1'b0);
    end
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_empty got v=%b want 0", bus.o_valid);
    end
    idle(1'b0, 1'b1);
    checks++;
    if (bus.o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr got ovf=%b want 0", bus.o_ovf);
    end
  endtask

  task automatic test_full_push_pop;
    logic [11:0] exp [4];
    exp = '{12'h112, 12'h113, 12'h114, 12'h1FF};
    for (int i = 1; i <= 4; i++) good(12'h110 + 12'(i), 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd4) begin
      errors++;
      $display("FAIL full_fill got c=%0d want 4", bus.o_count);
    end
    good(12'h1FF, 1'b1, 1'b0);
    checks++;
    if (bus.o_count !== 3'd4 || bus.o_ovf !== 1'b0 || bus.o_data !== 12'h112) begin
      errors++;
      $display("FAIL full_push_pop got c=%0d ovf=%b d=%h want c=4 ovf=0 d=112",
               bus.o_count, bus.o_ovf, bus.o_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp[i]) begin
        errors++;
        $display("FAIL full_drain %0d got v=%b d=%h want v=1 d=%h", i, bus.o_valid, bus.o_data, exp[i]);
      end
      idle(1'b1, 1'b0);
    end
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0) begin
      errors++;
      $display("FAIL full_empty got v=%b c=%0d want v=0 c=0", bus.o_valid, bus.o_count);
    end
  endtask

  task automatic test_fault;
    for (int i = 0; i < 3; i++) begin
      drive(12'h155, 12'h000, 1'b0, 1'b0);
      checks++;
      if (bus.o_fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_early %0d got %b want 0", i, bus.o_fault);
      end
    end
    drive(12'h155, 12'h000, 1'b0, 1'b0);
    checks++;
    if (bus.o_fault !== 1'b1 || bus.o_err !== 1'b1) begin
      errors++;
      $display("FAIL fault_entry got fault=%b err=%b want 1 1", bus.o_fault, bus.o_err);
    end
    good(12'h2AA, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd0 || bus.o_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_nostore got c=%0d fault=%b want c=0 fault=1", bus.o_count, bus.o_fault);
    end
    idle(1'b0, 1'b1);
    checks++;
    if (bus.o_fault !== 1'b0 || bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL fault_clr got fault=%b err=%b want 0 0", bus.o_fault, bus.o_err);
    end
    good(12'h2AA, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd1 || bus.o_data !== 12'h2AA) begin
      errors++;
      $display("FAIL fault_resume got c=%0d d=%h want c=1 d=2aa", bus.o_count, bus.o_data);
    end
    // Clear cycle is still FAULT, so the accompanying good word is dropped.
    for (int i = 0; i < 4; i++) drive(12'h155, 12'h000, 1'b0, 1'b0);
    good(12'h3C3, 1'b0, 1'b1);
    checks++;
    if (bus.o_fault !== 1'b0 || bus.o_count !== 3'd1 || bus.o_data !== 12'h2AA) begin
      errors++;
      $display("FAIL fault_clr_word got fault=%b c=%0d d=%h want 0 1 2aa",
               bus.o_fault, bus.o_count, bus.o_data);
    end
    drive(12'h155, 12'h000, 1'b0, 1'b1);
    checks++;
    if (bus.o_err !== 1'b1 || bus.o_fault !== 1'b0) begin
      errors++;
      $display("FAIL err_set_wins got err=%b fault=%b want 1 0", bus.o_err, bus.o_fault);
    end
    idle(1'b1, 1'b1);
    checks++;
    if (bus.o_err !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_final got err=%b v=%b want 0 0", bus.o_err, bus.o_valid);
    end
  endtask

  task automatic test_reset_mid;
    good(12'h501, 1'b0, 1'b0);
    good(12'h502, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(1'b0, 1'b0);
    rst_n = 1'b1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0 || bus.o_data !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid got v=%b c=%0d d=%h want 0 0 000", bus.o_valid, bus.o_count, bus.o_data);
    end
    good(12'h503, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 3'd1 || bus.o_data !== 12'h503) begin
      errors++;
      $display("FAIL reset_mid_push got c=%0d d=%h want 1 503", bus.o_count, bus.o_data);
    end
    idle(1'b1, 1'b0);
  endtask

`ifdef BUS_RX_ERR_CNT_EN
  task automatic test_err_cnt;
    for (int i = 0; i < 300; i++) begin
      drive(12'h155, 12'h000, 1'b0, 1'b1);
      checks++;
      if (bus.o_fault !== 1'b0) begin
        errors++;
        $display("FAIL err_cnt_fault %0d got %b want 0", i, bus.o_fault);
      end
      if (i == 253 || i == 254) begin
        checks++;
        if (bus.o_err_cnt !== 8'(i + 1)) begin
          errors++;
          $display("FAIL err_cnt_ramp %0d got %0d want %0d", i, bus.o_err_cnt, i + 1);
        end
      end
    end
    checks++;
    if (bus.o_err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL err_cnt_sat got %0d want 255", bus.o_err_cnt);
    end
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    bus.i_Q     = 12'h000;
    bus.i_nQ    = 12'hFFF;
    bus.i_ready = 1'b0;
    bus.i_clr   = 1'b0;
    test_reset();
    test_latency();
    test_overflow();
    test_full_push_pop();
    test_fault();
    test_reset_mid();
`ifdef BUS_RX_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_bus_rx.md
# mod_bus_rx

Receiving end of the registered dual-rail `bus_t` link driven by the D-type flip-flop stage. It samples the true and complemented buses, checks that the two rails are exact complements, and discards idle words. Good words are buffered in a small FIFO and presented downstream on a valid/ready handshake. A fault state machine, sticky flags and an optional error counter make link integrity visible to the consumer.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, minimum 2.
- `FAULT_LIM`, 4: consecutive integrity errors that force the FAULT state; range 1..15.
- `i_clk` input 1: clock; all logic is on the rising edge.
- `i_rst_n` input 1: synchronous, active-low reset.
- `i_Q` input `bus_t` (12): true rail, `{tag[11:8], data[7:0]}`.
- `i_nQ` input `bus_t` (12): complement rail.
- `i_ready` input 1: downstream accepts `o_data` this cycle.
- `i_clr` input 1: clears `o_ovf` and `o_err`, and leaves FAULT.
- `o_valid` output 1: `o_data` holds a buffered word.
- `o_data` output `bus_t` (12): FIFO head word.
- `o_count` output $clog2(DEPTH)+1: FIFO occupancy.
- `o_ovf` output 1: sticky; a good word was dropped because the FIFO was full.
- `o_err` output 1: sticky; a rail mismatch was seen.
- `o_fault` output 1: the FSM is in FAULT.
- `o_err_cnt` output 8: saturating mismatch count; present only with `BUS_RX_ERR_CNT_EN`.

## Operation
- Each cycle the block classifies the input pair:
  - **mismatch**: `i_nQ != ~i_Q`.
  - **idle**: rails match and `i_Q.tag == 4'h0`. The transmitter outputs 0 when disabled, so tag 0 is reserved for idle.
  - **good**: rails match and tag is nonzero.
- FSM states: RUN and FAULT.
  - Reset enters RUN.
  - In RUN, a 4-bit run counter increments on each mismatch and clears on each idle or good word.
  - When the run counter reaches `FAULT_LIM`, the FSM moves to FAULT.
  - In FAULT no words are written; the run counter holds.
  - `i_clr` moves FAULT to RUN and clears the run counter.
- Push: a good word in RUN writes to the FIFO when it is not full, or when it is full and a pop happens in the same cycle.
  - A good word arriving when the FIFO is full with no pop is dropped and sets `o_ovf`.
- Pop: occurs when `o_valid && i_ready`. `i_ready` while empty has no effect.
- Stored words keep their order. Mismatch and idle words are never stored.
- `o_err` is set on any mismatch, in either state.
- `i_clr` clears `o_ovf` and `o_err`. A set event in the same cycle as `i_clr` wins, so the flag ends up 1.
- `i_clr` does not flush the FIFO.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `o_count` distinguishes full (= `DEPTH`) from empty (= 0).

## Timing
- Reset values: `o_valid` = 0, `o_data` = 0, `o_count` = 0, `o_ovf` = 0, `o_err` = 0, `o_fault` = 0, `o_err_cnt` = 0. Pointers and run counter are 0; FSM is in RUN.
- Reset in the middle of operation discards FIFO contents on that edge.
- Latency: a good word sampled at edge N into an empty FIFO gives `o_valid` = 1 with that word on `o_data` in the cycle after edge N. There is no same-cycle bypass.
- `o_data` is the registered FIFO head. It changes only after a pop, or after a push into an empty FIFO.
- Pop handshake: when `o_valid && i_ready` at edge N, the next word, or `o_valid` = 0, appears after edge N.
- Simultaneous push and pop:
  - When full: both happen and `o_count` is unchanged.
  - When empty: only the push happens, since `o_valid` was 0.
- The mismatch on which the run counter reaches `FAULT_LIM` asserts `o_fault` after that edge.
- The mismatch that triggers FAULT is not stored.
- `i_clr` takes effect at the edge where it is sampled. In that same cycle the FSM is still FAULT, so an incoming word is not stored.

## Configuration
- Macro `BUS_RX_ERR_CNT_EN`.
- Defined: `o_err_cnt` exists. It increments on every mismatch, saturates at 255, and is cleared only by reset.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- **Reset and idle:** hold `i_rst_n` = 0 for 2 cycles, then drive `i_Q` = 12'h000, `i_nQ` = 12'hFFF for 10 cycles. Required: all outputs stay 0 and `o_count` = 0.
- **Single word latency:** drive `i_Q` = 12'h3A5, `i_nQ` = 12'hC5A for one cycle with `i_ready` = 0. Required: next cycle `o_valid` = 1, `o_data` = 12'h3A5, `o_count` = 1. Raise `i_ready`: after one edge `o_valid` = 0.
- **Overflow:** with `DEPTH` = 4 and `i_ready` = 0, push good words 12'h101 through 12'h105. Required: `o_count` = 4, `o_ovf` = 1, and a pop sequence returns 101, 102, 103, 104.
- **Full with simultaneous push and pop:** with the FIFO full and `i_ready` = 1, push 12'h1FF. Required: `o_count` stays 4, `o_ovf` stays 0, and 1FF is the last word out.
- **Fault entry and exit:** drive 4 consecutive mismatches (`i_Q` = 12'h155, `i_nQ` = 12'h000), then a good word 12'h2AA. Required: `o_fault` = 1 after the 4th mismatch, `o_err` = 1, and 2AA is not stored. Pulse `i_clr`: `o_fault` = 0, `o_err` = 0, and the next good word is stored.
- **Error counter (with `BUS_RX_ERR_CNT_EN`):** drive 300 mismatches with `i_clr` pulsed each cycle. Required: `o_err_cnt` = 255 and `o_fault` = 0 throughout.
